// File: rtl/core_pkg.sv
// core_pkg
//   Shared register-file constants and types for the decode-stage scoreboard.
//   REG_ADDR_W / NUM_REGS  : architectural register addressing
//   reg_addr_t             : register index type
//   cnt_width()            : width needed to count 0..max_out inclusive
//   CNT_W                  : counter width for the default budget of 4
package core_pkg;

    localparam int REG_ADDR_W          = 5;
    localparam int NUM_REGS            = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/sb_counter.sv
// sb_counter
//   Up/down counter of in-flight long-latency operations, saturating at 0
//   and at MAX. An increment and a decrement in the same cycle cancel.
//   clk, rst   : clock, synchronous active-high reset
//   inc, dec   : one-cycle count requests
//   count      : current count
//   underflow  : combinational, dec requested while count is 0
module sb_counter
    import core_pkg::*;
#(
    parameter int MAX = MAX_OUTSTANDING_DEF,
    parameter int W   = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         underflow
);

    logic at_zero;
    logic at_max;

    assign at_zero   = (count == '0);
    assign at_max    = (count == W'(MAX));
    assign underflow = dec & at_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && !at_max) begin
            count <= count + W'(1);
        end else if (dec && !inc && !at_zero) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Register scoreboard and issue gate between decode and issue. Tracks the
//   destination registers of in-flight long-latency operations and stalls
//   decode on RAW/WAW hazards against them or when the outstanding budget
//   is exhausted. Write-back is not bypassed: a cleared bit only takes
//   effect at the next edge, so there is no path from wb_* to stall.
//   clk, rst           : clock, synchronous active-high reset
//   issue_*            : decoded instruction presented by decode
//   uses_rs1/uses_rs2  : instruction reads rs1/rs2
//   writes_rd          : instruction writes rd
//   issue_long         : long-latency instruction, reserves rd on issue
//   flush              : kill the presented instruction
//   wb_valid, wb_rd    : long-latency write-back
//   stall, issue_fire  : issue gate outputs (combinational)
//   pending            : per-register busy bits, bit 0 always 0
//   outstanding        : in-flight long-latency operation count
//   sb_error           : sticky protocol error
module issue_scoreboard
    import core_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   issue_valid,
    input  logic [REG_ADDR_W-1:0]                  issue_rs1,
    input  logic [REG_ADDR_W-1:0]                  issue_rs2,
    input  logic [REG_ADDR_W-1:0]                  issue_rd,
    input  logic                                   uses_rs1,
    input  logic                                   uses_rs2,
    input  logic                                   writes_rd,
    input  logic                                   issue_long,
    input  logic                                   flush,
    input  logic                                   wb_valid,
    input  logic [REG_ADDR_W-1:0]                  wb_rd,
    output logic                                   stall,
    output logic                                   issue_fire,
    output logic [NUM_REGS-1:0]                    pending,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0]  outstanding,
    output logic                                   sb_error
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);

    // DATA_WIDTH is carried only for uniform instantiation; reject nonsense.
    if (DATA_WIDTH < 1 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 31) begin : g_bad_params
        $error("issue_scoreboard: illegal parameter value");
    end

    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    reg_addr_t wrd;

    assign rs1 = issue_rs1;
    assign rs2 = issue_rs2;
    assign rd  = issue_rd;
    assign wrd = wb_rd;

    logic raw;
    logic waw;
    logic full;
    logic live;

    assign raw  = (uses_rs1 && rs1 != '0 && pending[rs1]) ||
                  (uses_rs2 && rs2 != '0 && pending[rs2]);
    assign waw  = writes_rd && rd != '0 && pending[rd];
    assign full = issue_long && (outstanding == CW'(MAX_OUTSTANDING));
    assign live = issue_valid && !flush;

    assign stall      = live && (raw || waw || full);
    assign issue_fire = live && !stall;

    // Every fired long op counts, even with rd=x0 or no write; its
    // completion then arrives as wb_rd=0.
    logic cnt_inc;
    logic cnt_underflow;

    assign cnt_inc = issue_fire && issue_long;

    sb_counter #(
        .MAX (MAX_OUTSTANDING),
        .W   (CW)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (cnt_inc),
        .dec       (wb_valid),
        .count     (outstanding),
        .underflow (cnt_underflow)
    );

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                stray_wb;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (cnt_inc && writes_rd && rd != '0) begin
            set_mask[rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_mask[wrd] = 1'b1;
        end
    end

    // A set and a clear of the same register cannot coincide: a pending rd
    // always stalls on WAW, so the order of mask application is irrelevant.
    always_comb begin
        pending_nxt    = (pending & ~clr_mask) | set_mask;
        pending_nxt[0] = 1'b0;
    end

    assign stray_wb = wb_valid && wrd != '0 && !pending[wrd];

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            sb_error <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (stray_wb || cnt_underflow) begin
                sb_error <= 1'b1;
            end
        end
    end

endmodule
